fx2_stream_writer: RTL and testbench
====================================

Name: fx2_stream_writer

Overview:
Parametrised FX2 slave-FIFO stream-IN writer. It is the successor of the fixed 8-bit EP6 writer.
- Buffers master words in an internal FIFO so short host-full stalls lose nothing.
- Supports 8/16-bit data, selectable endpoint and a configurable full policy (drop or stall).
- Terminates packets automatically at a maximum length.
- Sits between the maple-bus master and the FX2 GPIF slave-FIFO pins.

Parameters:
DATA_W, 8, FX2 data bus width; 8 or 16.
EP_ADDR, 2'b10, value driven on faddr (00 EP2, 01 EP4, 10 EP6, 11 EP8).
BUF_DEPTH, 16, internal buffer depth in words; power of 2, minimum 4.
MAX_PKT, 512, words per packet before a forced pkt_end; minimum 1.
FULL_POLICY, 0, 0 = drop rest of packet when host full, 1 = stall until not full.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
menable  in  1  master packet window; high = packet in progress
mready  in  1  mdata valid this cycle
mdata  in  DATA_W  master word
mbusy  out  1  buffer cannot accept; equals buf_full OR end_pending
flagd  in  1  FX2 EP full flag, active-low (0 = full)
fdata  out  DATA_W  FX2 data bus, registered
faddr  out  2  constant EP_ADDR
sloe  out  1  constant 1
slrd  out  1  constant 1
slwr  out  1  write strobe, active-low, registered
pkt_end  out  1  packet commit, active-low, registered
drop_count  out  16  words discarded by the DROP policy, saturating
overflow  out  1  sticky; a word was presented while mbusy=1

Behaviour:
Reset values (reset=0, effective immediately):
- slwr=1, pkt_end=1, fdata=0, mbusy=0, drop_count=0, overflow=0.
- Buffer emptied, word_cnt=0, end_pending=0, state=IDLE.

Master side:
- Push when menable & mready & !mbusy.
- mready & mbusy: word discarded, overflow<=1 (sticky until reset).
- Falling edge of menable (registered menable_d=1, menable=0) sets end_pending.
- end_pending holds mbusy high until the packet is closed, so packet boundaries never merge in the buffer.
- Push and pop in the same cycle are legal; occupancy is unchanged.

FSM (one-hot, next_state combinational, outputs registered from next_state):
- IDLE: buffer non-empty -> CHECK; else if end_pending -> CLOSE.
- CHECK: flagd=0 -> DROP if FULL_POLICY=0, else WAIT_FULL. flagd=1 -> SETUP.
- WAIT_FULL: slwr stays 1 while flagd=0; flagd=1 -> SETUP.
- SETUP: fdata <= buffer head, pop -> WRITE.
- WRITE: slwr=0 for exactly this one cycle; fdata is stable from SETUP through WRITE; word_cnt++.
  - If word_cnt+1 = MAX_PKT -> PKTEND.
  - Else if buffer non-empty -> CHECK.
  - Else -> IDLE.
- CLOSE: word_cnt>0 -> PKTEND; word_cnt=0 -> IDLE and clear end_pending. No zero-length packet is issued.
- PKTEND: pkt_end=0 for one cycle; word_cnt<=0; end_pending<=0 only if it was set; fdata<=0 -> IDLE.
- DROP: pop one word per cycle and increment drop_count (holds at 0xFFFF).
  - Exit when buffer empty & end_pending.
  - Exit goes to PKTEND if word_cnt>0 (commit the partial packet), else IDLE with end_pending cleared.
- Unreachable encoding -> IDLE.

Timing:
- Throughput: one word per 3 cycles (CHECK, SETUP, WRITE).
- Latency: word pushed at edge N, slwr low during cycle N+3 (IDLE->CHECK->SETUP->WRITE).

Boundary conditions:
- MAX_PKT reached mid-window: forced pkt_end; later words start a new packet. A later menable fall with word_cnt=0 produces no pulse.
- flagd sampled only in CHECK and WAIT_FULL; flagd falling during SETUP/WRITE does not abort that write.
- DROP entered with menable still high continues discarding incoming words until end_pending.

Decomposition:
- fx2_pkg: state one-hot constants (IDLE, CHECK, WAIT_FULL, SETUP, WRITE, CLOSE, PKTEND, DROP); endpoint constants FX2_EP2..FX2_EP8; POLICY_DROP/POLICY_STALL.
- Sub-module fx2_word_fifo: synchronous FIFO (WIDTH, DEPTH) with push, pop, head, empty, full, asynchronous active-low reset.

Test Plan:
- Reset, then idle 5 cycles -> slwr=1, pkt_end=1, fdata=0, faddr=2'b10, mbusy=0, overflow=0.
- flagd=1; push 0x11,0x22,0x33,0x44 back-to-back; drop menable -> four single-cycle slwr lows with fdata 0x11..0x44 in order, then one pkt_end low; drop_count=0.
- MAX_PKT=4; push 6 words then drop menable -> pkt_end after word 4, two more writes, second pkt_end; no third pulse.
- FULL_POLICY=0; flagd=0; push 5 words, drop menable -> no slwr, drop_count=5, no pkt_end (word_cnt=0).
- FULL_POLICY=1, BUF_DEPTH=16; flagd=0 while pushing 17 words -> mbusy=1 after 16 buffered, word 17 sets overflow=1. Release flagd -> 16 writes in order, no drops.
- Assert reset during a WRITE cycle -> slwr=1 immediately; after release the buffer is empty and no further slwr occurs.

Source files
------------

// File: rtl/fx2_pkg.sv
// Shared types and constants for the FX2 slave-FIFO stream-IN writer.
package fx2_pkg;

   typedef enum logic [7:0] {
      ST_IDLE      = 8'b0000_0001,
      ST_CHECK     = 8'b0000_0010,
      ST_WAIT_FULL = 8'b0000_0100,
      ST_SETUP     = 8'b0000_1000,
      ST_WRITE     = 8'b0001_0000,
      ST_CLOSE     = 8'b0010_0000,
      ST_PKTEND    = 8'b0100_0000,
      ST_DROP      = 8'b1000_0000
   } fx2_state_e;

   localparam logic [1:0] FX2_EP2 = 2'b00;
   localparam logic [1:0] FX2_EP4 = 2'b01;
   localparam logic [1:0] FX2_EP6 = 2'b10;
   localparam logic [1:0] FX2_EP8 = 2'b11;

   localparam int POLICY_DROP  = 0;
   localparam int POLICY_STALL = 1;

endpackage

// File: rtl/fx2_stream_writer_if.sv
// Master-side word stream into the FX2 writer: packet window, word strobe, data, busy.
interface fx2_stream_writer_if #(
   parameter int DATA_W = 8
);
   logic              menable;
   logic              mready;
   logic [DATA_W-1:0] mdata;
   logic              mbusy;

   modport master (output menable, output mready, output mdata, input mbusy);
   modport slave  (input menable, input mready, input mdata, output mbusy);

endinterface

// File: rtl/fx2_word_fifo.sv
// Synchronous word FIFO, head visible combinationally; a push while full is ignored.
module fx2_word_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
      else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
   end

endmodule

// File: rtl/fx2_stream_writer.sv
// FX2 slave-FIFO stream-IN writer: buffered master words out as slwr strobes, 3 cycles/word.
// mbusy holds off the master while the buffer is full or a packet close is pending.
module fx2_stream_writer
   import fx2_pkg::*;
#(
   parameter int         DATA_W      = 8,
   parameter logic [1:0] EP_ADDR     = FX2_EP6,
   parameter int         BUF_DEPTH   = 16,
   parameter int         MAX_PKT     = 512,
   parameter int         FULL_POLICY = POLICY_DROP
) (
   input  logic              clk,
   input  logic              reset,
   fx2_stream_writer_if.slave m_if,
   input  logic              flagd,
   output logic [DATA_W-1:0] fdata,
   output logic [1:0]        faddr,
   output logic              sloe,
   output logic              slrd,
   output logic              slwr,
   output logic              pkt_end,
   output logic [15:0]       drop_count,
   output logic              overflow
);
   localparam int CNT_W = $clog2(MAX_PKT + 1);

   fx2_state_e        state_q, state_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic [DATA_W-1:0] fdata_q, fdata_d;
   logic              slwr_q, slwr_d;
   logic              pkt_end_q, pkt_end_d;
   logic              end_pending_q, end_pending_d;
   logic              menable_q, menable_d;
   logic              overflow_q, overflow_d;

   logic              buf_push, buf_pop, buf_empty, buf_full;
   logic [DATA_W-1:0] buf_head;
   logic              mbusy, menable_fall, end_clr;

   assign mbusy        = buf_full || end_pending_q;
   assign buf_push     = m_if.menable && m_if.mready && !mbusy;
   assign menable_fall = menable_q && !m_if.menable;
   assign m_if.mbusy   = mbusy;

   fx2_word_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (buf_push),
      .push_dat (m_if.mdata),
      .pop      (buf_pop),
      .head     (buf_head),
      .empty    (buf_empty),
      .full     (buf_full)
   );

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      drop_cnt_d = drop_cnt_q;
      buf_pop    = 1'b0;
      end_clr    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!buf_empty)         state_d = ST_CHECK;
            else if (end_pending_q) state_d = ST_CLOSE;
         end
         ST_CHECK: begin
            if (flagd)                             state_d = ST_SETUP;
            else if (FULL_POLICY == POLICY_STALL)  state_d = ST_WAIT_FULL;
            else                                   state_d = ST_DROP;
         end
         ST_WAIT_FULL: begin
            if (flagd) state_d = ST_SETUP;
         end
         ST_SETUP: begin
            buf_pop = 1'b1;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (word_cnt_d == CNT_W'(MAX_PKT)) state_d = ST_PKTEND;
            else if (!buf_empty)                 state_d = ST_CHECK;
            else                                 state_d = ST_IDLE;
         end
         ST_CLOSE: begin
            if (word_cnt_q != '0) begin
               state_d = ST_PKTEND;
            end else begin
               state_d = ST_IDLE;
               end_clr = 1'b1;
            end
         end
         ST_PKTEND: begin
            word_cnt_d = '0;
            // A forced commit with words still buffered leaves the pending close for them.
            end_clr    = buf_empty;
            state_d    = ST_IDLE;
         end
         ST_DROP: begin
            if (!buf_empty) begin
               buf_pop = 1'b1;
               if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end else if (end_pending_q) begin
               if (word_cnt_q != '0) begin
                  state_d = ST_PKTEND;
               end else begin
                  state_d = ST_IDLE;
                  end_clr = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      end_pending_d = end_pending_q;
      if (end_clr)      end_pending_d = 1'b0;
      if (menable_fall) end_pending_d = 1'b1;
   end

   always_comb begin
      slwr_d     = (state_d != ST_WRITE);
      pkt_end_d  = (state_d != ST_PKTEND);
      fdata_d    = fdata_q;
      if (state_d == ST_SETUP)       fdata_d = buf_head;
      else if (state_d == ST_PKTEND) fdata_d = '0;
      menable_d  = m_if.menable;
      overflow_d = overflow_q || (m_if.mready && mbusy);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         word_cnt_q    <= '0;
         drop_cnt_q    <= '0;
         fdata_q       <= '0;
         slwr_q        <= 1'b1;
         pkt_end_q     <= 1'b1;
         end_pending_q <= 1'b0;
         menable_q     <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         word_cnt_q    <= word_cnt_d;
         drop_cnt_q    <= drop_cnt_d;
         fdata_q       <= fdata_d;
         slwr_q        <= slwr_d;
         pkt_end_q     <= pkt_end_d;
         end_pending_q <= end_pending_d;
         menable_q     <= menable_d;
         overflow_q    <= overflow_d;
      end
   end

   assign fdata      = fdata_q;
   assign faddr      = EP_ADDR;
   assign sloe       = 1'b1;
   assign slrd       = 1'b1;
   assign slwr       = slwr_q;
   assign pkt_end    = pkt_end_q;
   assign drop_count = drop_cnt_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_fx2_stream_writer.sv
// Scoreboard bench: dut_a uses defaults (drop policy), dut_b uses MAX_PKT=4 with stall policy.
module tb_fx2_stream_writer;

   typedef struct packed {
      logic       is_pkt;
      logic [7:0] dat;
   } evt_t;

   logic       clk;
   logic       reset;
   logic       menable_s [2];
   logic       mready_s  [2];
   logic [7:0] mdata_s   [2];
   logic       flagd_s   [2];
   logic       mbusy_w   [2];
   logic [7:0] fdata_w   [2];
   logic [1:0] faddr_w   [2];
   logic       sloe_w    [2];
   logic       slrd_w    [2];
   logic       slwr_w    [2];
   logic       pkt_end_w [2];
   logic [15:0] drop_w   [2];
   logic       ovf_w     [2];

   evt_t exp_q [2][$];
   int   wr_cnt [2];
   int   errors = 0;
   int   checks = 0;

   fx2_stream_writer_if #(.DATA_W(8)) if_a ();
   fx2_stream_writer_if #(.DATA_W(8)) if_b ();

   assign if_a.menable = menable_s[0];
   assign if_a.mready  = mready_s[0];
   assign if_a.mdata   = mdata_s[0];
   assign mbusy_w[0]   = if_a.mbusy;
   assign if_b.menable = menable_s[1];
   assign if_b.mready  = mready_s[1];
   assign if_b.mdata   = mdata_s[1];
   assign mbusy_w[1]   = if_b.mbusy;

   fx2_stream_writer #(
      .DATA_W(8), .EP_ADDR(2'b10), .BUF_DEPTH(16), .MAX_PKT(512), .FULL_POLICY(0)
   ) dut_a (
      .clk(clk), .reset(reset), .m_if(if_a), .flagd(flagd_s[0]),
      .fdata(fdata_w[0]), .faddr(faddr_w[0]), .sloe(sloe_w[0]), .slrd(slrd_w[0]),
      .slwr(slwr_w[0]), .pkt_end(pkt_end_w[0]), .drop_count(drop_w[0]), .overflow(ovf_w[0])
   );

   fx2_stream_writer #(
      .DATA_W(8), .EP_ADDR(2'b10), .BUF_DEPTH(16), .MAX_PKT(4), .FULL_POLICY(1)
   ) dut_b (
      .clk(clk), .reset(reset), .m_if(if_b), .flagd(flagd_s[1]),
      .fdata(fdata_w[1]), .faddr(faddr_w[1]), .sloe(sloe_w[1]), .slrd(slrd_w[1]),
      .slwr(slwr_w[1]), .pkt_end(pkt_end_w[1]), .drop_count(drop_w[1]), .overflow(ovf_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // Every slwr or pkt_end low cycle must match the next expected event for that DUT.
   always @(negedge clk) begin
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            if (!slwr_w[d] || !pkt_end_w[d]) begin
               if (!slwr_w[d]) wr_cnt[d]++;
               if (exp_q[d].size() == 0) begin
                  chk($sformatf("dut%0d_spurious_strobe", d),
                      {30'b0, pkt_end_w[d], slwr_w[d]}, 32'd3);
               end else begin
                  evt_t e;
                  e = exp_q[d].pop_front();
                  chk($sformatf("dut%0d_event", d),
                      {22'b0, pkt_end_w[d], slwr_w[d], fdata_w[d]},
                      e.is_pkt ? {22'b0, 1'b0, 1'b1, 8'h00} : {22'b0, 1'b1, 1'b0, e.dat});
               end
            end
         end
      end
   end

   // Drives one packet window; words with index >= cap are expected to be refused.
   task automatic send_pkt(input int d, input int n, input int cap, input logic [7:0] base,
                           input int max_pkt, input bit expect_out);
      int   wc;
      evt_t e;
      wc = 0;
      @(posedge clk); #1;
      menable_s[d] = 1'b1;
      for (int i = 0; i < n; i++) begin
         mready_s[d] = 1'b1;
         mdata_s[d]  = base + 8'(i * 17);
         if (i == cap) chk($sformatf("dut%0d_mbusy_when_full", d), mbusy_w[d], 1);
         if (expect_out && i < cap) begin
            e.is_pkt = 1'b0;
            e.dat    = mdata_s[d];
            exp_q[d].push_back(e);
            wc++;
            if (wc == max_pkt) begin
               e.is_pkt = 1'b1;
               e.dat    = 8'h00;
               exp_q[d].push_back(e);
               wc = 0;
            end
         end
         @(posedge clk); #1;
      end
      mready_s[d] = 1'b0;
      @(posedge clk); #1;
      menable_s[d] = 1'b0;
      if (expect_out && wc > 0) begin
         e.is_pkt = 1'b1;
         e.dat    = 8'h00;
         exp_q[d].push_back(e);
      end
   endtask

   task automatic drain(input int d, input string tag);
      int k;
      k = 0;
      while (exp_q[d].size() != 0 && k < 400) begin
         @(posedge clk);
         k++;
      end
      repeat (12) @(posedge clk);
      #1;
      chk(tag, exp_q[d].size(), 0);
   endtask

   initial begin
      int base_cnt;
      bit found;
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         menable_s[d] = 1'b0;
         mready_s[d]  = 1'b0;
         mdata_s[d]   = 8'h00;
         flagd_s[d]   = 1'b1;
         wr_cnt[d]    = 0;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("dut%0d_rst_slwr", d), slwr_w[d], 1);
         chk($sformatf("dut%0d_rst_pkt_end", d), pkt_end_w[d], 1);
         chk($sformatf("dut%0d_rst_fdata", d), fdata_w[d], 0);
         chk($sformatf("dut%0d_rst_faddr", d), faddr_w[d], 2'b10);
         chk($sformatf("dut%0d_rst_mbusy", d), mbusy_w[d], 0);
         chk($sformatf("dut%0d_rst_overflow", d), ovf_w[d], 0);
         chk($sformatf("dut%0d_rst_drop", d), drop_w[d], 0);
         chk($sformatf("dut%0d_sloe_slrd", d), {sloe_w[d], slrd_w[d]}, 2'b11);
      end

      // Four words, one packet.
      send_pkt(0, 4, 4, 8'h11, 512, 1'b1);
      drain(0, "a_basic_drain");
      chk("a_basic_drop_count", drop_w[0], 0);

      // MAX_PKT=4 with 6 words: forced commit, then close of the 2-word tail.
      send_pkt(1, 6, 6, 8'h51, 4, 1'b1);
      drain(1, "b_maxpkt_drain");

      // Host full under drop policy: everything discarded, no zero-length commit.
      flagd_s[0] = 1'b0;
      send_pkt(0, 5, 5, 8'h21, 512, 1'b0);
      drain(0, "a_drop_drain");
      repeat (10) @(posedge clk);
      #1;
      chk("a_drop_count", drop_w[0], 5);
      chk("a_drop_mbusy_released", mbusy_w[0], 0);
      flagd_s[0] = 1'b1;

      // Host full under stall policy: 16 buffered, 17th refused, then all 16 written.
      chk("b_overflow_before", ovf_w[1], 0);
      flagd_s[1] = 1'b0;
      base_cnt = wr_cnt[1];
      send_pkt(1, 17, 16, 8'h01, 4, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      chk("b_overflow_set", ovf_w[1], 1);
      chk("b_no_write_while_full", wr_cnt[1] - base_cnt, 0);
      flagd_s[1] = 1'b1;
      drain(1, "b_stall_drain");
      chk("b_stall_drop_count", drop_w[1], 0);

      // Reset in the middle of a write cycle.
      send_pkt(0, 3, 3, 8'hA1, 512, 1'b1);
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
         @(negedge clk);
         if (!slwr_w[0]) found = 1'b1;
      end
      chk("a_write_seen_before_rst", found, 1);
      #1 reset = 1'b0;
      #1;
      chk("a_rst_mid_write_slwr", slwr_w[0], 1);
      chk("a_rst_mid_write_pkt_end", pkt_end_w[0], 1);
      chk("a_rst_mid_write_fdata", fdata_w[0], 0);
      exp_q[0].delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      base_cnt = wr_cnt[0];
      repeat (30) @(posedge clk);
      #1;
      chk("a_no_write_after_rst", wr_cnt[0] - base_cnt, 0);
      chk("a_mbusy_after_rst", mbusy_w[0], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
